stack_run_ctrl: RTL and testbench
=================================

// Module: stack_run_ctrl
// PURPOSE
//  Run controller for the 12-bit-instruction stack machine core. It streams a program from a host
//  into code memory, clears the core, then sequences execution (run, single-step, stop, breakpoint),
//  detects the HALT opcode, counts retired instructions and traps on timeout or a stalled guard.
//  It sits between the host/testbench and the core's rule-enable/guard.
// PARAMETERS
//  AW         8        code-memory address width (= core pc width)
//  IW         12       instruction width; opcode = instr[3:0], operand = instr[IW-1:4]
//  HALT_OP    4'hB     opcode that stops execution (never fired into the core)
//  CW         16       width of the retired-instruction counter
//  MAX_CYCLES 0        retired-count limit for FAULT(timeout); 0 disables
//  STALL_MAX  8        consecutive enabled cycles with core_guard=0 before FAULT(stall)
// PORTS
//  clk        in   1      clock
//  rst_n      in   1      reset, synchronous, active-low
//  cmd_valid  in   1      host command strobe (accepted every cycle; cmd_ready is implied 1)
//  cmd_op     in   3      0 LOAD, 1 RUN, 2 STEP, 3 STOP, 4 CLEAR
//  ld_valid   in   1      program word valid (LOAD state only)
//  ld_ready   out  1      1 only in LOAD
//  ld_data    in   IW     program word
//  ld_last    in   1      final word of program
//  code_we    out  1      code-memory write enable (registered)
//  code_waddr out  AW     code-memory write address
//  code_wdata out  IW     code-memory write data
//  core_clr   out  1      1-cycle pulse: core clears pc, sp
//  core_en    out  1      core fires its rule this cycle (only effective when core_guard=1)
//  core_guard in   1      core rule guard
//  core_pc    in   AW     current pc
//  core_instr in   IW     instruction at pc
//  bp_en      in   1      breakpoint enable
//  bp_addr    in   AW     breakpoint pc
//  state      out  3      0 IDLE, 1 LOAD, 2 RUN, 3 STEP, 4 HALT, 5 FAULT
//  halt_cause out  2      0 none, 1 HALT_OP, 2 breakpoint, 3 STOP/step-done
//  fault_code out  2      0 none, 1 load overflow, 2 timeout, 3 stall
//  retired    out  CW     instructions retired since last LOAD/CLEAR (saturating)
//  err_cmd    out  1      1-cycle pulse: command illegal in current state, otherwise ignored
// BEHAVIOUR
//  Reset (rst_n=0 at posedge): state IDLE; all outputs 0; addr/stall/retired counters 0; mid-load
//   words discarded, memory contents untouched.
//  fire = core_en & core_guard. core_en combinational: state in {RUN,STEP} & opcode!=HALT_OP &
//   ~(bp_en & core_pc==bp_addr & ~bp_skip) & ~stop_seen.
//  IDLE/HALT: LOAD -> LOAD (waddr<=0, core_clr pulse); RUN/STEP -> RUN/STEP, set bp_skip, clear
//   halt_cause; CLEAR -> core_clr pulse, retired<=0, stay. STOP illegal.
//  LOAD: word accepted on ld_valid&ld_ready; written to code_waddr the next cycle (code_we=1),
//   address +1 per word. ld_last -> IDLE after its write. Word accepted at address 2^AW-1 without
//   ld_last -> FAULT code 1. Only CLEAR legal (aborts to IDLE).
//  RUN: opcode==HALT_OP -> HALT cause 1 next cycle, no fire. Breakpoint hit -> HALT cause 2,
//   no fire. bp_skip clears after first fire so the instruction at bp_addr executes on resume.
//  STEP: exactly one fire, then HALT cause 3; HALT_OP/breakpoint take priority as in RUN.
//  STOP in RUN/STEP at cycle t: fire at t permitted; core_en=0 from t+1; HALT cause 3 at t+1.
//  retired +1 per fire, saturates at all-ones. MAX_CYCLES!=0 & retired reaches it -> FAULT 2.
//  Stall counter +1 each cycle core_en=1 & core_guard=0, cleared on fire; ==STALL_MAX -> FAULT 3.
//  FAULT: core_en=0; only CLEAR legal -> IDLE, fault_code<=0. Any other cmd -> err_cmd pulse.
//  Simultaneous: FAULT check > HALT_OP > breakpoint > STOP > step-done.
// TESTING
//  LOAD 3 words (0x0A0,0x020,0x00B, last on 3rd) -> code_we at addrs 0,1,2; state IDLE; ld_ready 0.
//  RUN with mem[2]=0x00B, guard=1 -> exactly 2 fires, state HALT, halt_cause 1, retired 2.
//  bp_addr=1, RUN -> HALT cause 2 with pc=1, retired 1; RUN again -> instr 1 fires, then HALT_OP.
//  STEP from HALT at pc=0 -> one core_en pulse, retired +1, halt_cause 3; STOP in IDLE -> err_cmd.
//  core_guard held 0 in RUN, STALL_MAX=8 -> FAULT code 3 after 8 cycles; CLEAR -> IDLE, retired 0.
//  Streaming 256 words with no ld_last -> FAULT 1; rst_n=0 mid-RUN -> IDLE, core_en 0 next cycle.

Source files
------------

// File: rtl/stack_run_ctrl.sv
// stack_run_ctrl: run controller for the 12-bit stack machine core.
// Streams a program into code memory, clears the core and sequences
// run / single-step / stop / breakpoint, with halt, timeout and stall traps.
module stack_run_ctrl #(
    parameter int         AW         = 8,
    parameter int         IW         = 12,
    parameter logic [3:0] HALT_OP    = 4'hB,
    parameter int         CW         = 16,
    parameter int         MAX_CYCLES = 0,
    parameter int         STALL_MAX  = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cmd_valid,
    input  logic [2:0]    cmd_op,
    input  logic          ld_valid,
    output logic          ld_ready,
    input  logic [IW-1:0] ld_data,
    input  logic          ld_last,
    output logic          code_we,
    output logic [AW-1:0] code_waddr,
    output logic [IW-1:0] code_wdata,
    output logic          core_clr,
    output logic          core_en,
    input  logic          core_guard,
    input  logic [AW-1:0] core_pc,
    input  logic [IW-1:0] core_instr,
    input  logic          bp_en,
    input  logic [AW-1:0] bp_addr,
    output logic [2:0]    state,
    output logic [1:0]    halt_cause,
    output logic [1:0]    fault_code,
    output logic [CW-1:0] retired,
    output logic          err_cmd
);

    localparam int SW = (STALL_MAX < 2) ? 1 : $clog2(STALL_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_RUN   = 3'd2,
        S_STEP  = 3'd3,
        S_HALT  = 3'd4,
        S_FAULT = 3'd5
    } state_e;

    localparam logic [2:0] CMD_LOAD  = 3'd0;
    localparam logic [2:0] CMD_RUN   = 3'd1;
    localparam logic [2:0] CMD_STEP  = 3'd2;
    localparam logic [2:0] CMD_STOP  = 3'd3;
    localparam logic [2:0] CMD_CLEAR = 3'd4;

    state_e        state_q;
    logic [AW-1:0] addr_q;
    logic          bp_skip_q;
    logic [SW-1:0] stall_q;
    logic [CW-1:0] retired_q;
    logic [1:0]    halt_cause_q;
    logic [1:0]    fault_code_q;
    logic          err_cmd_q;
    logic          core_clr_q;
    logic          code_we_q;
    logic [AW-1:0] code_waddr_q;
    logic [IW-1:0] code_wdata_q;

    logic          halt_op_s;
    logic          bp_hit_s;
    logic          fire_s;
    logic [CW-1:0] retired_d;
    logic [SW-1:0] stall_d;
    logic          stall_fault_s;
    logic          timeout_s;
    logic          unused_operand_s;

    // The operand field is executed by the core; the controller only decodes the opcode.
    assign unused_operand_s = ^core_instr[IW-1:4];

    assign ld_ready   = (state_q == S_LOAD);
    assign code_we    = code_we_q;
    assign code_waddr = code_waddr_q;
    assign code_wdata = code_wdata_q;
    assign core_clr   = core_clr_q;
    assign state      = state_q;
    assign halt_cause = halt_cause_q;
    assign fault_code = fault_code_q;
    assign retired    = retired_q;
    assign err_cmd    = err_cmd_q;

    // Decode halt/breakpoint, gate the core rule and compute counter next values.
    // A STOP moves the FSM straight to HALT, so no separate stop flag is needed to drop core_en.
    always_comb begin
        halt_op_s     = (core_instr[3:0] == HALT_OP);
        bp_hit_s      = bp_en && (core_pc == bp_addr) && !bp_skip_q;
        core_en       = ((state_q == S_RUN) || (state_q == S_STEP)) && !halt_op_s && !bp_hit_s;
        fire_s        = core_en && core_guard;
        retired_d     = retired_q;
        stall_d       = stall_q;
        stall_fault_s = 1'b0;
        if (fire_s) begin
            stall_d = {SW{1'b0}};
            if (retired_q != {CW{1'b1}}) begin
                retired_d = retired_q + {{(CW-1){1'b0}}, 1'b1};
            end else begin
                retired_d = retired_q;
            end
        end else if (core_en) begin
            stall_d       = stall_q + {{(SW-1){1'b0}}, 1'b1};
            stall_fault_s = (stall_d == SW'(STALL_MAX));
        end else begin
            stall_d = stall_q;
        end
        timeout_s = (MAX_CYCLES != 0) && fire_s && (retired_d == CW'(MAX_CYCLES));
    end

    // Control FSM: command decode, program load, run sequencing and traps.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            addr_q       <= {AW{1'b0}};
            bp_skip_q    <= 1'b0;
            stall_q      <= {SW{1'b0}};
            retired_q    <= {CW{1'b0}};
            halt_cause_q <= 2'd0;
            fault_code_q <= 2'd0;
            err_cmd_q    <= 1'b0;
            core_clr_q   <= 1'b0;
            code_we_q    <= 1'b0;
            code_waddr_q <= {AW{1'b0}};
            code_wdata_q <= {IW{1'b0}};
        end else begin
            code_we_q  <= 1'b0;
            core_clr_q <= 1'b0;
            err_cmd_q  <= 1'b0;
            retired_q  <= retired_d;
            stall_q    <= stall_d;
            if (fire_s) begin
                bp_skip_q <= 1'b0;
            end
            case (state_q)
                S_IDLE, S_HALT: begin
                    if (cmd_valid) begin
                        case (cmd_op)
                            CMD_LOAD: begin
                                state_q    <= S_LOAD;
                                addr_q     <= {AW{1'b0}};
                                core_clr_q <= 1'b1;
                                retired_q  <= {CW{1'b0}};
                            end
                            CMD_RUN, CMD_STEP: begin
                                state_q      <= (cmd_op == CMD_RUN) ? S_RUN : S_STEP;
                                bp_skip_q    <= 1'b1;
                                halt_cause_q <= 2'd0;
                                stall_q      <= {SW{1'b0}};
                            end
                            CMD_CLEAR: begin
                                core_clr_q <= 1'b1;
                                retired_q  <= {CW{1'b0}};
                            end
                            default: err_cmd_q <= 1'b1;
                        endcase
                    end
                end
                S_LOAD: begin
                    if (cmd_valid && (cmd_op == CMD_CLEAR)) begin
                        state_q    <= S_IDLE;
                        core_clr_q <= 1'b1;
                        retired_q  <= {CW{1'b0}};
                    end else begin
                        err_cmd_q <= cmd_valid;
                        if (ld_valid) begin
                            code_we_q    <= 1'b1;
                            code_waddr_q <= addr_q;
                            code_wdata_q <= ld_data;
                            addr_q       <= addr_q + {{(AW-1){1'b0}}, 1'b1};
                            if (ld_last) begin
                                state_q <= S_IDLE;
                            end else if (addr_q == {AW{1'b1}}) begin
                                state_q      <= S_FAULT;
                                fault_code_q <= 2'd1;
                            end
                        end
                    end
                end
                S_RUN, S_STEP: begin
                    err_cmd_q <= cmd_valid && (cmd_op != CMD_STOP);
                    if (stall_fault_s) begin
                        state_q      <= S_FAULT;
                        fault_code_q <= 2'd3;
                    end else if (timeout_s) begin
                        state_q      <= S_FAULT;
                        fault_code_q <= 2'd2;
                    end else if (halt_op_s) begin
                        state_q      <= S_HALT;
                        halt_cause_q <= 2'd1;
                    end else if (bp_hit_s) begin
                        state_q      <= S_HALT;
                        halt_cause_q <= 2'd2;
                    end else if ((cmd_valid && (cmd_op == CMD_STOP)) ||
                                 ((state_q == S_STEP) && fire_s)) begin
                        state_q      <= S_HALT;
                        halt_cause_q <= 2'd3;
                    end
                end
                S_FAULT: begin
                    if (cmd_valid && (cmd_op == CMD_CLEAR)) begin
                        state_q      <= S_IDLE;
                        fault_code_q <= 2'd0;
                        core_clr_q   <= 1'b1;
                        retired_q    <= {CW{1'b0}};
                    end else begin
                        err_cmd_q <= cmd_valid;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_stack_run_ctrl.sv
// Scoreboard bench for stack_run_ctrl: expected writes, fires and error
// pulses are queued by the stimulus and checked by an independent monitor.
module tb_stack_run_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid;
    logic [2:0]  cmd_op;
    logic        ld_valid;
    logic        ld_ready;
    logic [11:0] ld_data;
    logic        ld_last;
    logic        code_we;
    logic [7:0]  code_waddr;
    logic [11:0] code_wdata;
    logic        core_clr;
    logic        core_en;
    logic        core_guard;
    logic [7:0]  core_pc;
    logic [11:0] core_instr;
    logic        bp_en;
    logic [7:0]  bp_addr;
    logic [2:0]  state;
    logic [1:0]  halt_cause;
    logic [1:0]  fault_code;
    logic [15:0] retired;
    logic        err_cmd;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [7:0]  a;
        logic [11:0] d;
    } wr_t;

    wr_t        exp_wr[$];
    logic [7:0] exp_fire[$];
    logic [2:0] exp_err[$];
    wr_t        mon_w;

    logic [11:0] mem [0:255];
    logic [7:0]  pc_q;

    always #5 clk = ~clk;

    stack_run_ctrl #(
        .AW(8), .IW(12), .HALT_OP(4'hB), .CW(16), .MAX_CYCLES(0), .STALL_MAX(8)
    ) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_op(cmd_op),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_data(ld_data), .ld_last(ld_last),
        .code_we(code_we), .code_waddr(code_waddr), .code_wdata(code_wdata),
        .core_clr(core_clr), .core_en(core_en), .core_guard(core_guard),
        .core_pc(core_pc), .core_instr(core_instr), .bp_en(bp_en), .bp_addr(bp_addr),
        .state(state), .halt_cause(halt_cause), .fault_code(fault_code),
        .retired(retired), .err_cmd(err_cmd)
    );

    // Code memory and a minimal core: pc advances on every fire.
    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 12'h000;
    end
    always @(posedge clk) begin
        if (code_we) mem[code_waddr] <= code_wdata;
        if (!rst_n || core_clr) pc_q <= 8'd0;
        else if (core_en && core_guard) pc_q <= pc_q + 8'd1;
    end
    assign core_pc    = pc_q;
    assign core_instr = mem[pc_q];

    // Monitor: pop expected events whenever the DUT presents one.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (code_we) begin
                checks++;
                if (exp_wr.size() == 0) begin
                    errors++;
                    $display("FAIL wr_unexpected actual addr=%0h data=%0h required none", code_waddr, code_wdata);
                end else begin
                    mon_w = exp_wr.pop_front();
                    if (code_waddr !== mon_w.a || code_wdata !== mon_w.d) begin
                        errors++;
                        $display("FAIL wr actual addr=%0h data=%0h required addr=%0h data=%0h",
                                 code_waddr, code_wdata, mon_w.a, mon_w.d);
                    end
                end
            end
            if (core_en && core_guard) begin
                checks++;
                if (exp_fire.size() == 0) begin
                    errors++;
                    $display("FAIL fire_unexpected actual pc=%0h required none", core_pc);
                end else if (core_pc !== exp_fire[0]) begin
                    errors++;
                    $display("FAIL fire_pc actual=%0h required=%0h", core_pc, exp_fire[0]);
                    void'(exp_fire.pop_front());
                end else begin
                    void'(exp_fire.pop_front());
                end
            end
            if (err_cmd) begin
                checks++;
                if (exp_err.size() == 0) begin
                    errors++;
                    $display("FAIL err_unexpected actual state=%0d required none", state);
                end else if (state !== exp_err[0]) begin
                    errors++;
                    $display("FAIL err_state actual=%0d required=%0d", state, exp_err[0]);
                    void'(exp_err.pop_front());
                end else begin
                    void'(exp_err.pop_front());
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic drain(input string nm);
        chk({nm, "_wr_left"},   exp_wr.size(),   32'd0);
        chk({nm, "_fire_left"}, exp_fire.size(), 32'd0);
        chk({nm, "_err_left"},  exp_err.size(),  32'd0);
    endtask

    task automatic cmd(input logic [2:0] op);
        cmd_valid = 1'b1;
        cmd_op    = op;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic wait_state(input logic [2:0] s, input int lim);
        for (int i = 0; i < lim && state !== s; i++) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [11:0] prog [0:2];
        logic [11:0] d;
        prog[0] = 12'h0A0; prog[1] = 12'h020; prog[2] = 12'h00B;
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 3'd0; ld_valid = 1'b0;
        ld_data = 12'h000; ld_last = 1'b0; core_guard = 1'b1; bp_en = 1'b0; bp_addr = 8'd0;
        tick(3);
        chk("rst_state", state, 32'd0);
        chk("rst_halt", halt_cause, 32'd0);
        chk("rst_fault", fault_code, 32'd0);
        chk("rst_retired", retired, 32'd0);
        chk("rst_ctl", {core_en, core_clr, code_we, err_cmd, ld_ready}, 32'd0);
        rst_n = 1'b1;
        tick(1);

        // STOP is illegal in IDLE
        exp_err.push_back(3'd0);
        cmd(3'd3);
        tick(2);
        chk("stop_idle_state", state, 32'd0);

        // LOAD three words
        cmd(3'd0);
        chk("load_state", state, 32'd1);
        chk("load_clr", core_clr, 32'd1);
        chk("load_ready", ld_ready, 32'd1);
        for (int i = 0; i < 3; i++) begin
            exp_wr.push_back({8'(i), prog[i]});
            ld_valid = 1'b1; ld_data = prog[i]; ld_last = (i == 2);
            @(posedge clk); #1;
        end
        ld_valid = 1'b0; ld_last = 1'b0;
        tick(1);
        chk("load_done_state", state, 32'd0);
        chk("load_done_ready", ld_ready, 32'd0);
        drain("load");

        // RUN to HALT_OP
        exp_fire.push_back(8'd0); exp_fire.push_back(8'd1);
        cmd(3'd1);
        wait_state(3'd4, 20);
        chk("run_state", state, 32'd4);
        chk("run_cause", halt_cause, 32'd1);
        chk("run_retired", retired, 32'd2);
        chk("run_en_off", core_en, 32'd0);
        drain("run");

        // Breakpoint at 1, then resume
        bp_en = 1'b1; bp_addr = 8'd1;
        cmd(3'd4);
        chk("clr_halt_state", state, 32'd4);
        chk("clr_retired", retired, 32'd0);
        exp_fire.push_back(8'd0);
        cmd(3'd1);
        wait_state(3'd4, 20);
        chk("bp_cause", halt_cause, 32'd2);
        chk("bp_pc", core_pc, 32'd1);
        chk("bp_retired", retired, 32'd1);
        exp_fire.push_back(8'd1);
        cmd(3'd1);
        wait_state(3'd4, 20);
        chk("bp_resume_cause", halt_cause, 32'd1);
        chk("bp_resume_retired", retired, 32'd2);
        drain("bp");
        bp_en = 1'b0;

        // Single step from pc 0
        cmd(3'd4);
        exp_fire.push_back(8'd0);
        cmd(3'd2);
        wait_state(3'd4, 20);
        tick(3);
        chk("step_state", state, 32'd4);
        chk("step_cause", halt_cause, 32'd3);
        chk("step_retired", retired, 32'd1);
        drain("step");

        // STOP in the first RUN cycle: that cycle's fire still counts
        cmd(3'd4);
        exp_fire.push_back(8'd0);
        cmd(3'd1);
        cmd(3'd3);
        chk("stop_state", state, 32'd4);
        chk("stop_cause", halt_cause, 32'd3);
        chk("stop_retired", retired, 32'd1);
        chk("stop_en_off", core_en, 32'd0);
        tick(2);
        drain("stop");

        // Stall fault after 8 guard-low cycles
        core_guard = 1'b0;
        cmd(3'd1);
        tick(7);
        chk("stall_7_state", state, 32'd2);
        tick(1);
        chk("stall_8_state", state, 32'd5);
        chk("stall_code", fault_code, 32'd3);
        chk("stall_en_off", core_en, 32'd0);
        core_guard = 1'b1;
        exp_err.push_back(3'd5);
        cmd(3'd1);
        tick(2);
        chk("fault_hold", state, 32'd5);
        cmd(3'd4);
        chk("fault_clr_state", state, 32'd0);
        chk("fault_clr_code", fault_code, 32'd0);
        chk("fault_clr_retired", retired, 32'd0);
        drain("stall");

        // Load overflow: 256 words without ld_last
        cmd(3'd0);
        for (int i = 0; i < 256; i++) begin
            d = 12'(i) ^ 12'h5A0;
            exp_wr.push_back({8'(i), d});
            ld_valid = 1'b1; ld_data = d;
            @(posedge clk); #1;
        end
        ld_valid = 1'b0;
        chk("ovf_state", state, 32'd5);
        chk("ovf_code", fault_code, 32'd1);
        chk("ovf_ready", ld_ready, 32'd0);
        tick(1);
        drain("ovf");
        cmd(3'd4);
        chk("ovf_clr_state", state, 32'd0);

        // Reset in the middle of a RUN
        core_guard = 1'b0;
        cmd(3'd1);
        tick(1);
        chk("mid_run_en", core_en, 32'd1);
        rst_n = 1'b0;
        tick(1);
        chk("mid_rst_state", state, 32'd0);
        chk("mid_rst_en", core_en, 32'd0);
        chk("mid_rst_fault", fault_code, 32'd0);
        rst_n = 1'b1;
        core_guard = 1'b1;
        tick(2);
        drain("final");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
